// File: rtl/alu_pipe_param.sv
// Parametrised pipelined ALU: a capture FSM pairs operands that may arrive on
// separate cycles, then a two-stage datapath returns each result 2 cycles after issue.
module alu_pipe_param #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            MODE,
  input  logic [CW-1:0]   CMD,
  input  logic [1:0]      INP_VALID,
  input  logic [DW-1:0]   OPA,
  input  logic [DW-1:0]   OPB,
  input  logic            CIN,
  output logic [2*DW-1:0] RES,
  output logic            RES_VALID,
  output logic            COUT,
  output logic            OFLOW,
  output logic            G,
  output logic            E,
  output logic            L,
  output logic            ERR
);

  localparam int RW = 2 * DW;
  localparam int LW = $clog2(DW);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  localparam logic [CW-1:0] AR_ADD = CW'(0),  AR_SUB = CW'(1),  AR_ADDC = CW'(2), AR_SUBC = CW'(3);
  localparam logic [CW-1:0] AR_INCA = CW'(4), AR_DECA = CW'(5), AR_INCB = CW'(6), AR_DECB = CW'(7);
  localparam logic [CW-1:0] AR_CMP = CW'(8),  AR_IMUL = CW'(9), AR_SMUL = CW'(10);
  localparam logic [CW-1:0] LG_AND = CW'(0),  LG_NAND = CW'(1), LG_OR = CW'(2),   LG_NOR = CW'(3);
  localparam logic [CW-1:0] LG_XOR = CW'(4),  LG_XNOR = CW'(5), LG_NOTA = CW'(6), LG_NOTB = CW'(7);
  localparam logic [CW-1:0] LG_SHRA = CW'(8), LG_SHLA = CW'(9), LG_SHRB = CW'(10), LG_SHLB = CW'(11);
  localparam logic [CW-1:0] LG_ROL = CW'(12), LG_ROR = CW'(13);

  typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_A} state_t;

  function automatic logic a_only(input logic m, input logic [CW-1:0] c);
    return m ? (c == AR_INCA || c == AR_DECA) : (c == LG_NOTA || c == LG_SHRA || c == LG_SHLA);
  endfunction

  function automatic logic b_only(input logic m, input logic [CW-1:0] c);
    return m ? (c == AR_INCB || c == AR_DECB) : (c == LG_NOTB || c == LG_SHRB || c == LG_SHLB);
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            ld_a, ld_b, ld_ctl, issue, tout, eval;
  logic [DW-1:0]   a_q, b_q;
  logic [CW-1:0]   cmd_q;
  logic            mode_q, cin_q, iss_v, iss_err;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_ctl  = 1'b0;
    issue   = 1'b0;
    tout    = 1'b0;
    eval    = 1'b0;
    case (state_q)
      WAIT_B: begin
        if (INP_VALID[1]) begin ld_b = 1'b1; issue = 1'b1; state_d = IDLE; end
        else if (INP_VALID[0]) eval = 1'b1;
        else if (cnt_q == CNT_LAST) begin issue = 1'b1; tout = 1'b1; state_d = IDLE; end
        else cnt_d = cnt_q + TW'(1);
      end
      WAIT_A: begin
        if (INP_VALID[0]) begin ld_a = 1'b1; issue = 1'b1; state_d = IDLE; end
        else if (INP_VALID[1]) eval = 1'b1;
        else if (cnt_q == CNT_LAST) begin issue = 1'b1; tout = 1'b1; state_d = IDLE; end
        else cnt_d = cnt_q + TW'(1);
      end
      default: eval = 1'b1;
    endcase
    // A lone operand (re)starts an issue exactly as it would from IDLE.
    if (eval) begin
      case (INP_VALID)
        2'b11: begin ld_a = 1'b1; ld_b = 1'b1; ld_ctl = 1'b1; issue = 1'b1; state_d = IDLE; end
        2'b01: begin
          ld_a = 1'b1; ld_ctl = 1'b1; cnt_d = '0;
          if (a_only(MODE, CMD)) begin issue = 1'b1; state_d = IDLE; end
          else state_d = WAIT_B;
        end
        2'b10: begin
          ld_b = 1'b1; ld_ctl = 1'b1; cnt_d = '0;
          if (b_only(MODE, CMD)) begin issue = 1'b1; state_d = IDLE; end
          else state_d = WAIT_A;
        end
        default: ;
      endcase
    end
  end

  // NOTE: data registers are reset too, so outputs are defined from the first reset edge on.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      iss_v   <= 1'b0;
      iss_err <= 1'b0;
    end else if (CE) begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_a) a_q <= OPA;
      if (ld_b) b_q <= OPB;
      if (ld_ctl) begin
        cmd_q  <= CMD;
        mode_q <= MODE;
        cin_q  <= CIN;
      end
      iss_v   <= issue;
      iss_err <= tout;
    end
  end

  logic            s1_v, s1_err, s1_mode, s1_cin;
  logic [CW-1:0]   s1_cmd;
  logic [DW-1:0]   s1_a, s1_b, s1_a_shl;
  logic [DW:0]     s1_a_inc, s1_b_inc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v     <= 1'b0;
      s1_err   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_cin   <= 1'b0;
      s1_cmd   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_a_shl <= '0;
      s1_a_inc <= '0;
      s1_b_inc <= '0;
    end else if (CE) begin
      s1_v     <= iss_v;
      s1_err   <= iss_err;
      s1_mode  <= mode_q;
      s1_cin   <= cin_q;
      s1_cmd   <= cmd_q;
      s1_a     <= a_q;
      s1_b     <= b_q;
      s1_a_shl <= {a_q[DW-2:0], 1'b0};
      s1_a_inc <= {1'b0, a_q} + (DW+1)'(1);
      s1_b_inc <= {1'b0, b_q} + (DW+1)'(1);
    end
  end

  logic [DW:0]   a_x, b_x, cin_x, add_x, addc_x;
  logic [DW-1:0] sub_r, subc_r, dec_a, dec_b, rol_r, ror_r;
  logic [RW-1:0] mul_i, mul_s;
  logic [LW-1:0] sh;
  logic [LW:0]   sh_c;

  assign a_x    = {1'b0, s1_a};
  assign b_x    = {1'b0, s1_b};
  assign cin_x  = (DW+1)'(s1_cin);
  assign add_x  = a_x + b_x;
  assign addc_x = a_x + b_x + cin_x;
  assign sub_r  = s1_a - s1_b;
  assign subc_r = s1_a - s1_b - DW'(s1_cin);
  assign dec_a  = s1_a - DW'(1);
  assign dec_b  = s1_b - DW'(1);
  assign mul_i  = RW'(s1_a_inc) * RW'(s1_b_inc);
  assign mul_s  = RW'(s1_a_shl) * RW'(s1_b);
  assign sh     = s1_b[LW-1:0];
  assign sh_c   = (LW+1)'(DW) - {1'b0, sh};
  assign rol_r  = (s1_a << sh) | (s1_a >> sh_c);
  assign ror_r  = (s1_a >> sh) | (s1_a << sh_c);

  logic [RW-1:0] res_d;
  logic [DW-1:0] lo_d;
  logic          cout_d, oflow_d, g_d, e_d, l_d, err_d;

  always_comb begin
    res_d = '0; lo_d = '0;
    cout_d = 1'b0; oflow_d = 1'b0; g_d = 1'b0; e_d = 1'b0; l_d = 1'b0; err_d = 1'b0;
    if (s1_v) begin
      if (s1_err) err_d = 1'b1;
      else if (s1_mode) begin
        case (s1_cmd)
          AR_ADD:  begin res_d = RW'(add_x);  cout_d = add_x[DW]; end
          AR_SUB:  begin res_d = RW'(sub_r);  oflow_d = (s1_a < s1_b); end
          AR_ADDC: begin res_d = RW'(addc_x); cout_d = addc_x[DW]; end
          AR_SUBC: begin res_d = RW'(subc_r); oflow_d = (a_x < (b_x + cin_x)); end
          AR_INCA: res_d = RW'(s1_a_inc);
          AR_DECA: res_d = RW'(dec_a);
          AR_INCB: res_d = RW'(s1_b_inc);
          AR_DECB: res_d = RW'(dec_b);
          AR_CMP:  begin g_d = (s1_a > s1_b); e_d = (s1_a == s1_b); l_d = (s1_a < s1_b); end
          AR_IMUL: res_d = mul_i;
          AR_SMUL: res_d = mul_s;
          default: err_d = 1'b1;
        endcase
      end else begin
        case (s1_cmd)
          LG_AND:  lo_d = s1_a & s1_b;
          LG_NAND: lo_d = ~(s1_a & s1_b);
          LG_OR:   lo_d = s1_a | s1_b;
          LG_NOR:  lo_d = ~(s1_a | s1_b);
          LG_XOR:  lo_d = s1_a ^ s1_b;
          LG_XNOR: lo_d = ~(s1_a ^ s1_b);
          LG_NOTA: lo_d = ~s1_a;
          LG_NOTB: lo_d = ~s1_b;
          LG_SHRA: lo_d = s1_a >> 1;
          LG_SHLA: lo_d = s1_a << 1;
          LG_SHRB: lo_d = s1_b >> 1;
          LG_SHLB: lo_d = s1_b << 1;
          LG_ROL:  begin lo_d = rol_r; err_d = |s1_b[DW-1:LW]; end
          LG_ROR:  begin lo_d = ror_r; err_d = |s1_b[DW-1:LW]; end
          default: err_d = 1'b1;
        endcase
        res_d = RW'(lo_d);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES       <= '0;
      COUT      <= 1'b0;
      OFLOW     <= 1'b0;
      G         <= 1'b0;
      E         <= 1'b0;
      L         <= 1'b0;
      ERR       <= 1'b0;
    end else if (CE) begin
      RES_VALID <= s1_v;
      RES       <= res_d;
      COUT      <= cout_d;
      OFLOW     <= oflow_d;
      G         <= g_d;
      E         <= e_d;
      L         <= l_d;
      ERR       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Bench for alu_pipe_param: vector table plus hand sequences feed a scoreboard
// queue that a negedge monitor checks for value, flags and arrival edge.
module tb_alu_pipe_param;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TIMEOUT = 16;

  localparam logic [5:0] F_0 = 6'b000000, F_COUT = 6'b100000, F_OFL = 6'b010000;
  localparam logic [5:0] F_G = 6'b001000, F_E = 6'b000100, F_L = 6'b000010, F_ERR = 6'b000001;

  logic            CLK = 1'b0;
  logic            RST, CE, MODE, CIN;
  logic [CW-1:0]   CMD;
  logic [1:0]      INP_VALID;
  logic [DW-1:0]   OPA, OPB;
  logic [2*DW-1:0] RES;
  logic            RES_VALID, COUT, OFLOW, G, E, L, ERR;

  alu_pipe_param #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .RES_VALID(RES_VALID),
    .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [15:0] res;
    logic [5:0] flg;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [5:0]  flg;
    int          edge_n;
    int          id;
  } exp_t;

  exp_t sb[$];
  vec_t vq[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   edges = 0;
  logic ce_last = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge CLK) begin
    edges   <= edges + 1;
    ce_last <= CE;
  end

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s id=%0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] iv, input logic m, input logic [3:0] c,
                       input logic [7:0] a, input logic [7:0] b, input logic ci);
    INP_VALID = iv; MODE = m; CMD = c; OPA = a; OPB = b; CIN = ci;
  endtask

  task automatic idle();
    INP_VALID = 2'b00;
  endtask

  task automatic expect_at(input logic [15:0] r, input logic [5:0] f, input int edge_n, input int id);
    exp_t e;
    e.res = r; e.flg = f; e.edge_n = edge_n; e.id = id;
    sb.push_back(e);
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    check("drain", id, sb.size(), 0);
    sb.delete();
  endtask

  function automatic vec_t mk(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                              input logic ci, input logic [15:0] r, input logic [5:0] f);
    vec_t v;
    v.mode = m; v.cmd = c; v.a = a; v.b = b; v.cin = ci; v.res = r; v.flg = f;
    return v;
  endfunction

  // Lone operand, then silence; the partner (if any) arrives on the last edge of the window.
  task automatic timeout_seq(input bit first_a, input bit partner, input int id);
    drive(first_a ? 2'b01 : 2'b10, 1'b1, 4'd0, 8'h12, 8'h34, 1'b0);
    tick();
    idle();
    repeat (TIMEOUT - 1) tick();
    if (partner) begin
      drive(first_a ? 2'b10 : 2'b01, 1'b1, 4'd1, 8'h12, 8'h34, 1'b1);
      tick();
      expect_at(16'h0046, F_0, edges + 2, id);
    end else begin
      tick();
      expect_at(16'h0000, F_ERR, edges + 2, id);
    end
    idle();
    drain(id);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (RES_VALID && ce_last) begin
        if (sb.size() == 0) check("spurious_valid", -1, 1, 0);
        else begin
          cur = sb.pop_front();
          check("res", cur.id, RES, cur.res);
          check("flags", cur.id, {COUT, OFLOW, G, E, L, ERR}, cur.flg);
          check("arrival_edge", cur.id, edges, cur.edge_n);
        end
      end else if (!RES_VALID) begin
        check("zero_when_idle", -1, {RES, COUT, OFLOW, G, E, L, ERR}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    RST = 1'b1; CE = 1'b1;
    drive(2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) tick();
    check("reset_state", 0, {RES_VALID, RES, COUT, OFLOW, G, E, L, ERR}, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    tick();

    vq.push_back(mk(1, 0,  8'hFF, 8'h01, 0, 16'h0100, F_COUT));
    vq.push_back(mk(1, 0,  8'h12, 8'h34, 0, 16'h0046, F_0));
    vq.push_back(mk(1, 1,  8'h05, 8'h07, 0, 16'h00FE, F_OFL));
    vq.push_back(mk(1, 1,  8'h07, 8'h05, 0, 16'h0002, F_0));
    vq.push_back(mk(1, 2,  8'hFF, 8'h00, 1, 16'h0100, F_COUT));
    vq.push_back(mk(1, 2,  8'h10, 8'h20, 1, 16'h0031, F_0));
    vq.push_back(mk(1, 3,  8'h05, 8'h05, 1, 16'h00FF, F_OFL));
    vq.push_back(mk(1, 3,  8'h09, 8'h05, 1, 16'h0003, F_0));
    vq.push_back(mk(1, 4,  8'hFF, 8'h00, 0, 16'h0100, F_0));
    vq.push_back(mk(1, 5,  8'h00, 8'h00, 0, 16'h00FF, F_0));
    vq.push_back(mk(1, 6,  8'h00, 8'hFF, 0, 16'h0100, F_0));
    vq.push_back(mk(1, 7,  8'h00, 8'h00, 0, 16'h00FF, F_0));
    vq.push_back(mk(1, 9,  8'h03, 8'h04, 0, 16'h0014, F_0));
    vq.push_back(mk(1, 8,  8'h07, 8'h07, 0, 16'h0000, F_E));
    vq.push_back(mk(1, 0,  8'h01, 8'h01, 0, 16'h0002, F_0));
    vq.push_back(mk(1, 8,  8'h09, 8'h03, 0, 16'h0000, F_G));
    vq.push_back(mk(1, 8,  8'h02, 8'h05, 0, 16'h0000, F_L));
    vq.push_back(mk(1, 9,  8'hFF, 8'hFF, 0, 16'h0000, F_0));
    vq.push_back(mk(1, 9,  8'h00, 8'h00, 0, 16'h0001, F_0));
    vq.push_back(mk(1, 10, 8'h81, 8'h03, 0, 16'h0006, F_0));
    vq.push_back(mk(1, 10, 8'h7F, 8'hFF, 0, 16'hFD02, F_0));
    vq.push_back(mk(1, 11, 8'h12, 8'h34, 0, 16'h0000, F_ERR));
    vq.push_back(mk(1, 15, 8'h12, 8'h34, 1, 16'h0000, F_ERR));
    vq.push_back(mk(0, 0,  8'hF0, 8'h3C, 0, 16'h0030, F_0));
    vq.push_back(mk(0, 1,  8'hF0, 8'h3C, 0, 16'h00CF, F_0));
    vq.push_back(mk(0, 2,  8'hF0, 8'h3C, 0, 16'h00FC, F_0));
    vq.push_back(mk(0, 3,  8'hF0, 8'h3C, 0, 16'h0003, F_0));
    vq.push_back(mk(0, 4,  8'hF0, 8'h3C, 0, 16'h00CC, F_0));
    vq.push_back(mk(0, 5,  8'hF0, 8'h3C, 0, 16'h0033, F_0));
    vq.push_back(mk(0, 6,  8'h0F, 8'h00, 0, 16'h00F0, F_0));
    vq.push_back(mk(0, 7,  8'h00, 8'hA5, 0, 16'h005A, F_0));
    vq.push_back(mk(0, 8,  8'h81, 8'h00, 0, 16'h0040, F_0));
    vq.push_back(mk(0, 9,  8'h81, 8'h00, 0, 16'h0002, F_0));
    vq.push_back(mk(0, 10, 8'h00, 8'h81, 0, 16'h0040, F_0));
    vq.push_back(mk(0, 11, 8'h00, 8'h81, 0, 16'h0002, F_0));
    vq.push_back(mk(0, 12, 8'h81, 8'h11, 0, 16'h0003, F_ERR));
    vq.push_back(mk(0, 12, 8'h81, 8'h03, 0, 16'h000C, F_0));
    vq.push_back(mk(0, 13, 8'h81, 8'h01, 0, 16'h00C0, F_0));
    vq.push_back(mk(0, 13, 8'h81, 8'h80, 0, 16'h0081, F_ERR));
    vq.push_back(mk(0, 14, 8'h12, 8'h34, 0, 16'h0000, F_ERR));

    // Back-to-back issues, one per cycle.
    for (int i = 0; i < vq.size(); i++) begin
      drive(2'b11, vq[i].mode, vq[i].cmd, vq[i].a, vq[i].b, vq[i].cin);
      tick();
      expect_at(vq[i].res, vq[i].flg, edges + 2, i);
    end
    idle();
    drain(99);

    // Split SUB: partner's CMD/OPA/CIN are ignored.
    drive(2'b01, 1'b1, 4'd1, 8'h05, 8'h00, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    drive(2'b10, 1'b1, 4'd0, 8'hAA, 8'h07, 1'b1);
    tick();
    expect_at(16'h00FE, F_OFL, edges + 2, 100);
    idle();
    drain(100);

    // Single-operand commands issue immediately.
    drive(2'b01, 1'b0, 4'd6, 8'h0F, 8'h00, 1'b0);
    tick();
    expect_at(16'h00F0, F_0, edges + 2, 101);
    drive(2'b10, 1'b1, 4'd6, 8'h00, 8'hFF, 1'b0);
    tick();
    expect_at(16'h0100, F_0, edges + 2, 102);
    drive(2'b01, 1'b1, 4'd5, 8'h00, 8'h33, 1'b0);
    tick();
    expect_at(16'h00FF, F_0, edges + 2, 103);
    idle();
    drain(103);

    // A second lone A re-latches A and control before B arrives.
    drive(2'b01, 1'b1, 4'd0, 8'h03, 8'h00, 1'b0);
    tick();
    drive(2'b01, 1'b1, 4'd2, 8'h10, 8'h00, 1'b1);
    tick();
    idle();
    tick();
    drive(2'b10, 1'b1, 4'd0, 8'h77, 8'h01, 1'b0);
    tick();
    expect_at(16'h0012, F_0, edges + 2, 104);
    idle();
    drain(104);

    timeout_seq(1'b1, 1'b0, 110);
    timeout_seq(1'b1, 1'b1, 111);
    timeout_seq(1'b0, 1'b0, 112);
    timeout_seq(1'b0, 1'b1, 113);

    // Reset one cycle after an issue discards it.
    drive(2'b11, 1'b1, 4'd0, 8'h01, 8'h01, 1'b0);
    tick();
    idle();
    RST = 1'b1;
    tick();
    check("rst_outputs", 120, {RES_VALID, RES, COUT, OFLOW, G, E, L, ERR}, 0);
    RST = 1'b0;
    repeat (4) tick();

    // Reset with CE=0 while waiting for B returns the FSM to IDLE.
    drive(2'b01, 1'b1, 4'd0, 8'h50, 8'h00, 1'b0);
    tick();
    idle();
    CE = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    CE = 1'b1;
    drive(2'b11, 1'b1, 4'd0, 8'h01, 8'h02, 1'b0);
    tick();
    expect_at(16'h0003, F_0, edges + 2, 121);
    idle();
    drain(121);

    // CE=0 for 3 cycles mid-pipeline delays the result by 3; inputs meanwhile are ignored.
    drive(2'b11, 1'b1, 4'd0, 8'h10, 8'h20, 1'b0);
    tick();
    expect_at(16'h0030, F_0, edges + 5, 130);
    CE = 1'b0;
    drive(2'b11, 1'b1, 4'd0, 8'hFF, 8'hFF, 1'b0);
    repeat (3) tick();
    CE = 1'b1;
    idle();
    drain(130);

    // CE=0 while RES_VALID is high holds the strobe and result.
    drive(2'b11, 1'b1, 4'd0, 8'h0A, 8'h0B, 1'b0);
    tick();
    expect_at(16'h0015, F_0, edges + 2, 131);
    idle();
    repeat (2) tick();
    CE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_valid", 131, RES_VALID, 1);
      check("hold_res", 131, RES, 16'h0015);
    end
    CE = 1'b1;
    tick();
    check("valid_drop", 131, RES_VALID, 0);
    drain(131);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
Parametrised, pipelined successor to the team's 8-bit ALU.
- Pairs operands that arrive on separate cycles through an explicit capture FSM with a bounded timeout.
- Accepts one issue per cycle and returns every result at a fixed 2-cycle latency with a RES_VALID strobe.
- Sits between the operand-sequencing front end and the result bus; width and timeout are set by parameters.

Parameters:
DW, 8, operand width (>=4, power of 2)
CW, 4, command width (>=4)
TIMEOUT, 16, cycles a lone operand waits for its partner (>=2)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
CE  in  1  clock enable; 0 freezes all state and outputs
MODE  in  1  1=arithmetic, 0=logical
CMD  in  CW  command, sampled with the first operand of an issue
INP_VALID  in  2  bit0=OPA valid, bit1=OPB valid
OPA  in  DW  operand A
OPB  in  DW  operand B
CIN  in  1  carry/borrow in, sampled with CMD
RES  out  2*DW  result, zero-extended
RES_VALID  out  1  one-cycle strobe, RES/flags valid
COUT  out  1  carry out (ADD, ADD_CIN)
OFLOW  out  1  borrow (SUB, SUB_CIN)
G, E, L  out  1 each  compare flags (CMP)
ERR  out  1  error flag for this result

Behaviour:
Reset:
- RST=1 at an edge, regardless of CE: FSM->IDLE, wait counter=0, pipeline flushed.
- All outputs 0, including RES_VALID; never Z or X.
- Reset mid-wait or mid-pipeline discards the operation; no RES_VALID for it.

Command classes:
- A-only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
- B-only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
- All other valid commands are binary.

Capture FSM (IDLE, WAIT_B, WAIT_A); CE=1 required for any transition:
- IDLE, INP_VALID=11: latch A, B, CMD, MODE, CIN; issue.
- IDLE, 01: latch A, CMD, MODE, CIN. If CMD is A-only, issue; else go to WAIT_B, counter=0.
- IDLE, 10: mirror of 01 (B-only commands issue; otherwise go to WAIT_A).
- IDLE, 00: stay.
- WAIT_B, 10 or 11: latch OPB only (OPA, CMD, CIN on that cycle are ignored); issue; go to IDLE.
- WAIT_B, 01: re-latch A, CMD, MODE, CIN; restart counter; re-evaluate as in IDLE.
- WAIT_B, 00: counter+1. When counter==TIMEOUT-1 and no partner arrives, issue an error result (ERR=1, RES=0) and go to IDLE.
- Window: a first operand captured at edge N accepts its partner at edges N+1..N+TIMEOUT inclusive. A partner on edge N+TIMEOUT wins over timeout.
- WAIT_A: mirror of WAIT_B.

Pipeline:
- Stage 1 registers operands and pre-ops; stage 2 computes and registers outputs.
- An issue at edge N gives RES_VALID=1 with results from edge N+2 to edge N+3.
- Issues may occur back-to-back every cycle; ordering is preserved.
- CE=0 holds all pipeline registers, so RES_VALID holds its level.
- When RES_VALID=0, RES and all flags are 0.

Arithmetic (MODE=1):
- 0 ADD: RES = A+B; COUT = bit DW.
- 1 SUB: RES = (A-B) mod 2^DW; OFLOW = A<B.
- 2 ADD_CIN: RES = A+B+CIN; COUT = bit DW.
- 3 SUB_CIN: RES = (A-B-CIN) mod 2^DW; OFLOW = A<B+CIN.
- 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B: DW+1-bit result; DEC of 0 wraps to 2^DW-1; INC of max gives 2^DW.
- 8 CMP: exactly one of G/E/L = 1; RES=0.
- 9 INC_MUL: RES = (A+1)*(B+1); operands DW+1 bits, result truncated to 2*DW.
- 10 SHL_MUL: RES = ((A<<1) mod 2^DW) * B.

Logical (MODE=0), results are DW bits zero-extended:
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- 6 NOT_A, 7 NOT_B.
- 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
- 12 ROL: rotate A left by B[log2(DW)-1:0].
- 13 ROR: rotate A right by B[log2(DW)-1:0].
- ROL/ROR: if any higher bit of B is set, ERR=1 and the rotate result is still driven.

Errors:
- Any other CMD/MODE combination: RES=0, ERR=1, issued like a normal command.
- Flags not defined for a command are 0.

Test Plan:
- DW=8, IDLE, INP_VALID=11, MODE=1, CMD=0, A=0xFF, B=0x01 -> exactly 2 cycles later RES_VALID=1, RES=0x100, COUT=1, other flags 0.
- INP_VALID=01 (A=0x05, CMD=1 SUB), 3 idle cycles, then INP_VALID=10 with B=0x07 and CMD=0 -> SUB is used: RES=0xFE, OFLOW=1, 2 cycles after the B edge.
- INP_VALID=01 with binary CMD, then 00 for TIMEOUT=16 cycles -> RES_VALID 2 cycles after edge N+16 with ERR=1, RES=0. Repeat with B on edge N+16 -> normal result, ERR=0.
- Back-to-back 11 issues of MODE=1: CMD=9 (3,4), CMD=8 (7,7), CMD=0 (1,1) -> consecutive RES_VALID cycles: RES=20; then E=1, RES=0; then RES=2.
- MODE=0, CMD=12, A=0x81, B=0x11 -> RES=0x03, ERR=1. MODE=0, CMD=6, INP_VALID=01, A=0x0F -> RES=0xF0 with no wait.
- RST pulsed 1 cycle after an issue -> no RES_VALID for that issue, all outputs 0. CE=0 for 3 cycles mid-pipeline -> result delayed exactly 3 cycles, value unchanged.
